// File: rtl/reset_sync_seq_pkg.sv
// Shared definitions for the reset synchroniser / sequencer: FSM state
// encoding, legal parameter ranges and small elaboration-time helpers.
package reset_sync_seq_pkg;

  // Sequencer states, 2-bit binary encoding
  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2,
    ST_SW_HOLD = 2'd3
  } state_t;

  // Legal parameter ranges
  localparam int MIN_STAGES = 2;
  localparam int MAX_STAGES = 4;
  localparam int MIN_CH     = 1;
  localparam int MAX_CH     = 8;
  localparam int MIN_GAP    = 1;
  localparam int MIN_SW_RST = 1;

  // Larger of two integers, used to size the shared counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // True when every parameter lies inside its legal range
  function automatic bit params_legal(input int stages, input int ch,
                                      input int gap, input int sw);
    return (stages >= MIN_STAGES) && (stages <= MAX_STAGES) &&
           (ch >= MIN_CH) && (ch <= MAX_CH) &&
           (gap >= MIN_GAP) && (sw >= MIN_SW_RST);
  endfunction

endpackage

// File: rtl/mux2_cell.sv
// Generic 2:1 mux cell; kept as its own cell so the scan bypass path can be
// constrained / swapped for a library cell at implementation.
module mux2_cell (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/reset_sync_chain.sv
// Asynchronous-assert / synchronous-release reset synchroniser.
// The chain clears immediately when RST falls and shifts ones in after RST
// rises, so sync_rst_n goes high NUM_STAGES clock edges after release.
module reset_sync_chain #(
  parameter int NUM_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  output logic sync_rst_n
);

  logic [NUM_STAGES-1:0] stage_r;

  // Shift a constant one through the chain; cleared asynchronously by RST
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stage_r <= {NUM_STAGES{1'b0}};
    end else begin
      stage_r <= {stage_r[NUM_STAGES-2:0], 1'b1};
    end
  end

  assign sync_rst_n = stage_r[NUM_STAGES-1];

endmodule

// File: rtl/reset_sync_seq.sv
// Reset synchroniser plus release sequencer. After the synchronised release
// of RST, channel resets Sync_RST[k] are released one at a time, GAP_CYCLES
// apart, starting at bit 0. A software reset request in DONE pulls every
// channel back low for SW_RST_CYCLES and then replays the release sequence.
// Scan_mode bypasses everything so RST drives all reset outputs directly.
module reset_sync_seq
  import reset_sync_seq_pkg::*;
#(
  parameter int NUM_STAGES    = 2,
  parameter int NUM_CH        = 3,
  parameter int GAP_CYCLES    = 4,
  parameter int SW_RST_CYCLES = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Scan_mode,
  input  logic              Sw_rst_req,
  output logic [NUM_CH-1:0] Sync_RST,
  output logic              Rst_done
);

  localparam int CNT_MAX = max_int(GAP_CYCLES, SW_RST_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int IDX_W   = $clog2(NUM_CH) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SW_LAST  = CNT_W'(SW_RST_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

  // Reject out-of-range configurations at elaboration
  if (!params_legal(NUM_STAGES, NUM_CH, GAP_CYCLES, SW_RST_CYCLES)) begin : g_bad_params
    $error("reset_sync_seq: parameter out of legal range");
  end

  logic              sync_rst_n_s;
  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [IDX_W-1:0]  idx_r;
  logic [NUM_CH-1:0] rst_out_r;
  logic              done_r;
  logic [NUM_CH-1:0] rel_mask_s;

  reset_sync_chain #(
    .NUM_STAGES (NUM_STAGES)
  ) u_sync (
    .CLK        (CLK),
    .RST        (RST),
    .sync_rst_n (sync_rst_n_s)
  );

  // One-hot mask of the channel selected for the next release
  always_comb begin
    rel_mask_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      rel_mask_s[i] = (idx_r == IDX_W'(i));
    end
  end

  // Sequencer FSM; every output is a flop so releases only happen on CLK edges
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r   <= ST_HOLD;
      cnt_r     <= CNT_ZERO;
      idx_r     <= IDX_ZERO;
      rst_out_r <= {NUM_CH{1'b0}};
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_HOLD: begin
          rst_out_r <= {NUM_CH{1'b0}};
          done_r    <= 1'b0;
          cnt_r     <= CNT_ZERO;
          idx_r     <= IDX_ZERO;
          if (sync_rst_n_s) begin
            state_r <= ST_RELEASE;
          end else begin
            state_r <= ST_HOLD;
          end
        end

        ST_RELEASE: begin
          if (cnt_r == GAP_LAST) begin
            cnt_r     <= CNT_ZERO;
            rst_out_r <= rst_out_r | rel_mask_s;
            if (idx_r == IDX_LAST) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              idx_r <= idx_r + IDX_ONE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        ST_DONE: begin
          if (Sw_rst_req) begin
            rst_out_r <= {NUM_CH{1'b0}};
            done_r    <= 1'b0;
            cnt_r     <= CNT_ZERO;
            state_r   <= ST_SW_HOLD;
          end else begin
            state_r <= ST_DONE;
          end
        end

        ST_SW_HOLD: begin
          if (cnt_r == SW_LAST) begin
            cnt_r   <= CNT_ZERO;
            idx_r   <= IDX_ZERO;
            state_r <= ST_RELEASE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        default: begin
          state_r   <= ST_HOLD;
          cnt_r     <= CNT_ZERO;
          idx_r     <= IDX_ZERO;
          rst_out_r <= {NUM_CH{1'b0}};
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  // Scan bypass: RST straight to every reset output when Scan_mode is high
  for (genvar g = 0; g < NUM_CH; g++) begin : g_scan_mux
    mux2_cell u_mux (
      .a   (rst_out_r[g]),
      .b   (RST),
      .sel (Scan_mode),
      .y   (Sync_RST[g])
    );
  end

  mux2_cell u_done_mux (
    .a   (done_r),
    .b   (RST),
    .sel (Scan_mode),
    .y   (Rst_done)
  );

endmodule

// File: tb/tb_reset_sync_seq.sv
// Directed bench for reset_sync_seq. Two instances share clock, reset and
// scan: the default configuration and a 3-stage / 1-channel / gap-1 one.
module tb_reset_sync_seq;

  logic       CLK;
  logic       RST;
  logic       scan_mode;
  logic       sw_req;
  logic       sw_req2;
  logic [2:0] sync_rst;
  logic       rst_done;
  logic [0:0] sync_rst2;
  logic       rst_done2;

  int checks;
  int failures;

  reset_sync_seq dut (
    .CLK        (CLK),
    .RST        (RST),
    .Scan_mode  (scan_mode),
    .Sw_rst_req (sw_req),
    .Sync_RST   (sync_rst),
    .Rst_done   (rst_done)
  );

  reset_sync_seq #(
    .NUM_STAGES (3),
    .NUM_CH     (1),
    .GAP_CYCLES (1)
  ) dut2 (
    .CLK        (CLK),
    .RST        (RST),
    .Scan_mode  (scan_mode),
    .Sw_rst_req (sw_req2),
    .Sync_RST   (sync_rst2),
    .Rst_done   (rst_done2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] s, input logic d, input logic s2);
    check({tag, "_sync"}, {29'd0, sync_rst}, {29'd0, s});
    check({tag, "_done"}, {31'd0, rst_done}, {31'd0, d});
    check({tag, "_sync2"}, {31'd0, sync_rst2[0]}, {31'd0, s2});
    check({tag, "_done2"}, {31'd0, rst_done2}, {31'd0, s2});
  endtask

  // count edges driven with sw on the first edge, expected outputs after each
  typedef struct {
    int         count;
    logic       sw;
    logic [2:0] sync;
    logic       done;
    logic       s2;
  } vec_t;

  vec_t vecs [15];

  initial begin
    // Edge 0 is the first posedge after RST rises
    vecs[0]  = '{4, 1'b0, 3'b000, 1'b0, 1'b0}; // edges 0-3
    vecs[1]  = '{2, 1'b0, 3'b000, 1'b0, 1'b1}; // 4-5, dut2 released at 4
    vecs[2]  = '{2, 1'b0, 3'b001, 1'b0, 1'b1}; // 6-7
    vecs[3]  = '{2, 1'b1, 3'b001, 1'b0, 1'b1}; // 8-9, sw in RELEASE ignored
    vecs[4]  = '{2, 1'b0, 3'b011, 1'b0, 1'b1}; // 10-11
    vecs[5]  = '{2, 1'b1, 3'b011, 1'b0, 1'b1}; // 12-13, sw ignored
    vecs[6]  = '{2, 1'b0, 3'b111, 1'b1, 1'b1}; // 14-15, DONE
    vecs[7]  = '{1, 1'b1, 3'b000, 1'b0, 1'b1}; // 16, sw in DONE
    vecs[8]  = '{2, 1'b0, 3'b000, 1'b0, 1'b1}; // 17-18
    vecs[9]  = '{4, 1'b1, 3'b000, 1'b0, 1'b1}; // 19-22, sw in SW_HOLD ignored
    vecs[10] = '{2, 1'b0, 3'b000, 1'b0, 1'b1}; // 23-24, RELEASE at 24
    vecs[11] = '{3, 1'b1, 3'b000, 1'b0, 1'b1}; // 25-27, sw ignored
    vecs[12] = '{4, 1'b0, 3'b001, 1'b0, 1'b1}; // 28-31
    vecs[13] = '{4, 1'b0, 3'b011, 1'b0, 1'b1}; // 32-35
    vecs[14] = '{2, 1'b0, 3'b111, 1'b1, 1'b1}; // 36-37

    checks    = 0;
    failures  = 0;
    RST       = 1'b0;
    scan_mode = 1'b0;
    sw_req    = 1'b0;
    sw_req2   = 1'b0;

    // Reset state held across several edges
    repeat (3) @(posedge CLK);
    #1;
    check_all("reset", 3'b000, 1'b0, 1'b0);

    @(negedge CLK);
    RST = 1'b1;

    // Power-on release, software reset and ignored requests
    for (int r = 0; r < 15; r++) begin
      for (int j = 0; j < vecs[r].count; j++) begin
        sw_req = (j == 0) ? vecs[r].sw : 1'b0;
        @(posedge CLK);
        #1;
        check_all($sformatf("vec%0d_%0d", r, j), vecs[r].sync, vecs[r].done, vecs[r].s2);
      end
    end
    sw_req = 1'b0;

    // Re-run the release, then abort it mid-RELEASE with a short RST pulse
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    repeat (7) @(posedge CLK);
    #1;
    check_all("mid_release", 3'b001, 1'b0, 1'b1);
    #1;
    RST = 1'b0;
    #1;
    check_all("async_clear", 3'b000, 1'b0, 1'b0);
    #1;
    RST = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    check_all("restart_e3", 3'b000, 1'b0, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    check_all("restart_e5", 3'b000, 1'b0, 1'b1);
    @(posedge CLK);
    #1;
    check_all("restart_e6", 3'b001, 1'b0, 1'b1);
    repeat (7) @(posedge CLK);
    #1;
    check_all("restart_e13", 3'b011, 1'b0, 1'b1);
    @(posedge CLK);
    #1;
    check_all("restart_e14", 3'b111, 1'b1, 1'b1);

    // Scan bypass: outputs follow RST combinationally
    @(negedge CLK);
    scan_mode = 1'b1;
    #1;
    check_all("scan_rst1", 3'b111, 1'b1, 1'b1);
    RST = 1'b0;
    #1;
    check_all("scan_rst0", 3'b000, 1'b0, 1'b0);
    RST = 1'b1;
    #1;
    check_all("scan_rst1b", 3'b111, 1'b1, 1'b1);
    scan_mode = 1'b0;
    #1;
    check_all("scan_off", 3'b000, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reset_sync_seq.md
RESET_SYNC_SEQ -- requirements
Module: reset_sync_seq

Interface
REQ-001 Parameter NUM_STAGES, default 2, synchroniser depth; legal range 2..4.
REQ-002 Parameter NUM_CH, default 3, number of sequenced reset outputs; legal range 1..8.
REQ-003 Parameter GAP_CYCLES, default 4, CLK cycles between successive channel releases; legal range >=1.
REQ-004 Parameter SW_RST_CYCLES, default 8, software-reset hold length in CLK cycles; legal range >=1.
REQ-005 CLK  input  1  single functional clock; all state on posedge.
REQ-006 RST  input  1  asynchronous, active-low reset; asserts asynchronously, release synchronised internally.
REQ-007 Scan_mode  input  1  1 = test bypass, RST drives all reset outputs directly.
REQ-008 Sw_rst_req  input  1  single-cycle software reset request, synchronous to CLK.
REQ-009 Sync_RST  output  NUM_CH  active-low per-channel resets; bit 0 released first.
REQ-010 Rst_done  output  1  high once all channels are released.

Function
REQ-011 Synchroniser: NUM_STAGES-flop chain cleared by RST, shifting in 1; sync_rst_n = last stage; release seen NUM_STAGES edges after RST rises.
REQ-012 FSM states: HOLD, RELEASE, DONE, SW_HOLD; encoding is 2-bit binary.
REQ-013 HOLD: all Sync_RST=0, Rst_done=0; first edge with sync_rst_n=1 -> RELEASE, cnt=0, idx=0.
REQ-014 RELEASE: cnt increments each edge; when cnt==GAP_CYCLES-1, Sync_RST[idx]<=1, cnt<=0, idx<=idx+1.
REQ-015 Channel k deasserts exactly GAP_CYCLES*(k+1) edges after RELEASE entry; released channels stay 1.
REQ-016 Release of idx==NUM_CH-1 -> DONE with Rst_done<=1 on the same edge.
REQ-017 DONE: Sw_rst_req=1 -> all Sync_RST<=0, Rst_done<=0, cnt<=0, state SW_HOLD, all on one edge.
REQ-018 Sw_rst_req in HOLD, RELEASE or SW_HOLD is ignored; no queuing.
REQ-019 SW_HOLD: cnt increments; when cnt==SW_RST_CYCLES-1 -> RELEASE with cnt=0, idx=0, so outputs low for SW_RST_CYCLES+GAP_CYCLES*(k+1) edges per channel.
REQ-020 cnt width = clog2(max(GAP_CYCLES,SW_RST_CYCLES))+1; idx width = clog2(NUM_CH)+1; no wrap reachable.
REQ-021 Functional mode: Sync_RST and Rst_done driven directly from flops, no combinational logic after them.
REQ-022 Scan_mode=1: Sync_RST = {NUM_CH{RST}}, Rst_done = RST, via a 2:1 mux per output; internal state still runs.
REQ-023 NUM_CH=1: single release after GAP_CYCLES, Rst_done on same edge.

Reset
REQ-024 RST=0 asynchronously clears sync chain, Sync_RST=0, Rst_done=0, cnt=0, idx=0, state HOLD, irrespective of state.
REQ-025 RST asserted mid-RELEASE or mid-SW_HOLD aborts the sequence; restart always from channel 0 after resynchronised release.
REQ-026 No output ever deasserts asynchronously; deassertion only on posedge CLK.

Structure
REQ-027 Shared package holds FSM state typedef/localparams (HOLD, RELEASE, DONE, SW_HOLD) and parameter legal-range constants.
REQ-028 One sub-module, reset_sync_chain (NUM_STAGES, CLK, RST -> sync_rst_n), instantiated once; sequencer FSM in the top.
REQ-029 Scan bypass mux reuses the team's existing 2:1 mux cell per output bit.

Verification
REQ-030 Defaults, RST 0->1 at edge 0 -> sync high edge 2; Sync_RST = 001 at edge 2+4, 011 at +8, 111 at +12; Rst_done=1 at +12.
REQ-031 In DONE, 1-cycle Sw_rst_req -> next edge Sync_RST=000, Rst_done=0; 8 edges later RELEASE; 001 after 4 further edges, 111 after 12.
REQ-032 RST pulsed low 2 ns mid-RELEASE (Sync_RST=001) -> outputs 000 immediately, asynchronously; sequence restarts from bit 0 after release.
REQ-033 Sw_rst_req asserted during RELEASE and during SW_HOLD -> no change in release timing versus REQ-030/031.
REQ-034 Scan_mode=1, toggle RST 0/1 -> Sync_RST follows {3{RST}} and Rst_done follows RST combinationally; Scan_mode=0 restores registered values.
REQ-035 NUM_STAGES=3, NUM_CH=1, GAP_CYCLES=1 -> Sync_RST[0]=1 and Rst_done=1 at edge 4 after RST release.
